fetch_stage: RTL

Instruction fetch stage that sits directly upstream of `datapath`. It owns the fetch PC, issues in-order word requests to a variable-latency instruction memory over a valid/ready port, and buffers returned instructions with their PCs in a small FIFO. The FIFO feeds decode and the datapath through a valid/ready handshake. A branch/jump redirect flushes the buffer and discards in-flight responses.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fetch_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: word width, instruction size, reset PC
// and the fetch buffer entry layout.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    function automatic word_t pc_next(input word_t pc);
        return pc + word_t'(INSTR_BYTES);
    endfunction

    function automatic word_t pc_align(input word_t pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush. Pointers wrap naturally at DEPTH,
// which must be a power of two. Push and pop may coincide at any occupancy.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             pop_fire;
    logic             push_fire;

    assign empty     = (count == '0);
    assign full      = (count == COUNT_FULL);
    assign pop_fire  = pop && !empty;
    // A pop frees the slot this edge, so a full FIFO can still take a push.
    assign push_fire = push && (!full || pop_fire);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_fire && !pop_fire) begin
                count <= count + CW'(1);
            end else if (pop_fire && !push_fire) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues credit-limited in-order requests
// to instruction memory and buffers responses with their PCs for decode.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

    word_t         fetch_pc;
    word_t         rsp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight_after;
    logic [CW:0]   credit_used;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Buffered plus outstanding never exceeds DEPTH, so every response has a slot.
    assign credit_used    = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok      = credit_used < CREDIT_MAX;

    assign imem_req_valid = !rst && !redirect && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_fire       = imem_rsp_valid && (inflight != '0);
    assign rsp_keep       = rsp_fire && (drop == '0) && !redirect;
    assign inflight_after = inflight + CW'(req_fire) - CW'(rsp_fire);

    assign instr_valid    = (fifo_count != '0);
    assign pop            = instr_valid && instr_ready && !redirect;
    assign instr          = instr_valid ? head_entry.instr : '0;
    assign instr_pc       = instr_valid ? head_entry.pc    : '0;

    assign push_entry.pc    = rsp_pc;
    assign push_entry.instr = imem_rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_after;
            if (redirect) begin
                // Every request still outstanding predates the new PC; discard them all.
                fetch_pc <= pc_align(redirect_pc);
                rsp_pc   <= pc_align(redirect_pc);
                drop     <= inflight_after;
            end else begin
                if (req_fire) begin
                    fetch_pc <= pc_next(fetch_pc);
                end
                if (rsp_keep) begin
                    rsp_pc <= pc_next(rsp_pc);
                end else if (rsp_fire) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count)
    );

endmodule
